wave_display_core: RTL and testbench
====================================

# wave_display_core

Pixel generator for the oscilloscope view. It takes the VGA raster coordinate and draws the audio waveform from a 256-entry sample buffer as a thick white trace in the top half of the screen. It also overlays a song-number glyph and play, fast-forward and rewind status icons. It sits between the sample RAM (synchronous, 1-cycle read) and the VGA colour mux.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-low reset
- `x` in 11: raster column
- `y` in 10: raster row
- `valid` in 1: raster is inside the visible area
- `read_value` in 8: sample from RAM, 1 cycle after `read_address`
- `weight` in 2: trace thickness extension, 0..3 rows
- `ff_switch0` in 1: fast-forward active
- `r_switch1` in 1: rewind active
- `song_num` in 2: current song, 0..3
- `play` in 1: playback active
- `read_index` in 1: which half of the double-buffered RAM to display
- `read_address` out 9: RAM address, combinational
- `valid_pixel` out 1: pixel is inside the wave window
- `r`, `g`, `b` out 8 each: pixel colour

## Operation
- Wave window: `x[10:8]` is 3'b001 or 3'b010 (x 256..767), and `y[9]`=0 (y 0..511).
- `read_address` = {`read_index`, `x[9]`, `x[7:1]`}. Each sample is 2 pixels wide; 256 samples span the window.
- Stage 1 registers `x`, `y`, `valid` and the address, and captures `read_value`.
  - cur = {1'b0, `read_value[7:1]`} + 8'd32 (range 32..159).
  - When the stage-1 address differs from the previous stage-1 address: prev <= old cur.
- Hit condition: `y[8:1]` lies in [min(prev,cur) − `weight`, max(prev,cur) + `weight`]. Use 9-bit arithmetic, clamped at 0 and 255.
- Colour priority, evaluated only when `valid`=1:
  1. Wave hit inside the wave window → white (FF,FF,FF).
  2. Icon pixel → icon colour.
  3. Otherwise → black.
- `valid`=0 forces black and `valid_pixel`=0.
- `valid_pixel` = `valid` & wave-window condition, delayed to match the colour outputs.
- Icons (active only with the configuration macro):
  - Song glyph: x 815..822, y 463..470, 8×8 digit ROM indexed by `song_num`.
    - Row = y−463; column = x−815, MSB is the leftmost pixel.
    - Set pixels are yellow (FF,FF,00).
  - Play icon: x 825..832, y 480..487, right-pointing triangle.
  - Fast-forward icon: x 835..842, y 480..487, double right triangle.
  - Rewind icon: x 845..852, y 480..487, double left triangle.
  - Icon shape pixels are green (00,FF,00) when the matching input (`play`, `ff_switch0`, `r_switch1`) is 1, and gray (40,40,40) when 0.

## Timing
- Latency: a raster coordinate presented in cycle N produces `valid_pixel`, `r`, `g`, `b` in cycle N+2 (both stages are registered).
- `read_address` follows `x` and `read_index` combinationally, in the same cycle.
- `read_index` may change at any time; the trace uses whichever buffer is addressed when the sample is fetched.
- Reset (`reset`=0 at a clock edge):
  - Every output register, prev, cur and all pipeline registers clear to 0.
  - Outputs read 0 from the next cycle.
  - Deasserting reset mid-frame resumes the normal 2-cycle pipeline.
- An address change and a new `read_value` in the same cycle: prev takes the old cur and cur takes the new value in one edge.

## Configuration
- `WAVE_DISPLAY_ICONS_EN`:
  - Defined: song glyph and transport icons are drawn as described above.
  - Undefined: the icon logic is removed and `song_num`, `play`, `ff_switch0`, `r_switch1` are ignored. Non-wave pixels are black.

## Test plan
- Run all coordinates with `valid`=1 and compare `valid_pixel` 2 cycles later:
  - x=0, y=1023 → 0
  - x=256, y=1023 → 0
  - x=512, y=1023 → 0
  - x=0, y=0 → 0
  - x=512, y=511 → 1
  - x=280, y=511 → 1
- Address check: `read_index`=1, x=767 → `read_address`=9'h1FF. `read_index`=0, x=508 → `read_address`=9'h07E.
- Trace hit: with a RAM ramp so that cur=prev=100, `weight`=1, and y=200 (y[8:1]=100) inside the window, r,g,b = FF after 2 cycles. Moving to y=210 gives black.
- `valid`=0 at any in-window coordinate → `valid_pixel`=0 and r,g,b=0 after 2 cycles.
- Icons (macro defined):
  - `play`=1, x=828, y=483 → green.
  - `ff_switch0`=0, x=838, y=483 → gray.
  - Scan x 815..822 × y 463..470 with `song_num`=0 → output matches the digit-0 glyph ROM in yellow.
- Reset: drive `reset`=0 for 2 cycles during an active trace → all outputs 0 on the following cycle. Deassert → normal output resumes 2 cycles after the next coordinate.

Source files
------------

// File: rtl/wave_display_core.sv
// ============================================================================
// Module   : wave_display_core
// Purpose  : Oscilloscope pixel generator. Draws the sample-buffer waveform as
//            a thick white trace in the wave window (x 256..767, y 0..511) and,
//            when WAVE_DISPLAY_ICONS_EN is defined, overlays a song-number
//            glyph and play / fast-forward / rewind status icons.
//            Two registered stages: raster in cycle N -> colour in cycle N+2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wave_display_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  input  logic        valid,
  input  logic [7:0]  read_value,
  input  logic [1:0]  weight,
  input  logic        ff_switch0,
  input  logic        r_switch1,
  input  logic [1:0]  song_num,
  input  logic        play,
  input  logic        read_index,
  output logic [8:0]  read_address,
  output logic        valid_pixel,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b
);

  // Stage-1 raster copy and sample history
  logic [10:0] x_q;
  logic [9:0]  y_q;
  logic        valid_q;
  logic [8:0]  addr_q, addr_prev_q;
  logic [7:0]  cur_q, prev_q;
  // Stage-2 outputs
  logic        valid_pixel_q, valid_pixel_d;
  logic [23:0] rgb_q, rgb_d;

  // Two pixels per sample; x[8] is dropped so both window halves map linearly.
  assign read_address = {read_index, x[9], x[7:1]};

  // Sample arriving now belongs to addr_q; the previous sample becomes the
  // other trace end-point only when the stage-1 address moves on.
  logic [7:0] w_cur, w_prev, w_min, w_max, w_lo, w_hi;
  logic [8:0] w_lo9, w_hi9;
  logic       w_win, w_hit;

  assign w_cur  = {1'b0, read_value[7:1]} + 8'd32;
  assign w_prev = (addr_q != addr_prev_q) ? cur_q : prev_q;
  assign w_min  = (w_prev < w_cur) ? w_prev : w_cur;
  assign w_max  = (w_prev < w_cur) ? w_cur  : w_prev;
  assign w_lo9  = {1'b0, w_min} - {7'd0, weight};
  assign w_hi9  = {1'b0, w_max} + {7'd0, weight};
  assign w_lo   = w_lo9[8] ? 8'd0   : w_lo9[7:0];
  assign w_hi   = w_hi9[8] ? 8'd255 : w_hi9[7:0];
  assign w_hit  = (y_q[8:1] >= w_lo) && (y_q[8:1] <= w_hi);
  assign w_win  = ((x_q[10:8] == 3'b001) || (x_q[10:8] == 3'b010)) && !y_q[9];

  logic        w_icon_on;
  logic [23:0] w_icon_rgb;

`ifdef WAVE_DISPLAY_ICONS_EN
  function automatic logic [7:0] glyph_row(input logic [1:0] digit, input logic [2:0] row);
    logic [63:0] bitmap;
    case (digit)
      2'd0:    bitmap = 64'h3C66_6E76_6666_3C00;
      2'd1:    bitmap = 64'h1838_1818_1818_7E00;
      2'd2:    bitmap = 64'h3C66_060C_3060_7E00;
      default: bitmap = 64'h3C66_061C_0666_3C00;
    endcase
    glyph_row = bitmap[(7 - row) * 8 +: 8];
  endfunction

  logic [10:0] w_sdx, w_pdx, w_fdx, w_rdx;
  logic [9:0]  w_sdy, w_idy;
  logic        w_song_box, w_play_box, w_ff_box, w_rw_box;
  logic [7:0]  w_glyph;
  logic [2:0]  w_half;
  logic        w_song_px, w_play_px, w_ff_px, w_rw_px;

  assign w_sdx = x_q - 11'd815;
  assign w_pdx = x_q - 11'd825;
  assign w_fdx = x_q - 11'd835;
  assign w_rdx = x_q - 11'd845;
  assign w_sdy = y_q - 10'd463;
  assign w_idy = y_q - 10'd480;

  assign w_song_box = (x_q >= 11'd815) && (x_q <= 11'd822) && (y_q >= 10'd463) && (y_q <= 10'd470);
  assign w_play_box = (x_q >= 11'd825) && (x_q <= 11'd832) && (y_q >= 10'd480) && (y_q <= 10'd487);
  assign w_ff_box   = (x_q >= 11'd835) && (x_q <= 11'd842) && (y_q >= 10'd480) && (y_q <= 10'd487);
  assign w_rw_box   = (x_q >= 11'd845) && (x_q <= 11'd852) && (y_q >= 10'd480) && (y_q <= 10'd487);

  // Triangle half-width per row: 1,2,3,4,4,3,2,1
  assign w_half    = {1'b0, (w_idy[2] ? ~w_idy[1:0] : w_idy[1:0])} + 3'd1;
  assign w_glyph   = glyph_row(song_num, w_sdy[2:0]);
  assign w_song_px = w_song_box && w_glyph[3'd7 - w_sdx[2:0]];
  assign w_play_px = w_play_box && ({1'b0, w_pdx[2:0]} < {w_half, 1'b0});
  assign w_ff_px   = w_ff_box   && ({1'b0, w_fdx[1:0]} < w_half);
  assign w_rw_px   = w_rw_box   && ({1'b0, ~w_rdx[1:0]} < w_half);

  // Icon colour select: yellow glyph, green/gray transport shapes
  always_comb begin
    w_icon_on  = 1'b1;
    w_icon_rgb = 24'h000000;
    if (w_song_px)
      w_icon_rgb = 24'hFFFF00;
    else if (w_play_px)
      w_icon_rgb = play ? 24'h00FF00 : 24'h404040;
    else if (w_ff_px)
      w_icon_rgb = ff_switch0 ? 24'h00FF00 : 24'h404040;
    else if (w_rw_px)
      w_icon_rgb = r_switch1 ? 24'h00FF00 : 24'h404040;
    else
      w_icon_on = 1'b0;
  end
`else
  assign w_icon_on  = 1'b0;
  assign w_icon_rgb = 24'h000000;
`endif

  // Inputs and raster bits that only the icon overlay consumes
  logic unused_inputs;
  assign unused_inputs = ^{x_q[7:0], y_q[0], song_num, play, ff_switch0, r_switch1};

  // Stage-2 colour: wave beats icons beats black; invalid raster is black
  always_comb begin
    valid_pixel_d = valid_q & w_win;
    rgb_d         = 24'h000000;
    if (valid_q) begin
      if (w_win && w_hit)
        rgb_d = 24'hFFFFFF;
      else if (w_icon_on)
        rgb_d = w_icon_rgb;
    end
  end

  // Pipeline, sample history and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q           <= '0;
      y_q           <= '0;
      valid_q       <= 1'b0;
      addr_q        <= '0;
      addr_prev_q   <= '0;
      cur_q         <= '0;
      prev_q        <= '0;
      valid_pixel_q <= 1'b0;
      rgb_q         <= '0;
    end else begin
      x_q           <= x;
      y_q           <= y;
      valid_q       <= valid;
      addr_q        <= read_address;
      addr_prev_q   <= addr_q;
      cur_q         <= w_cur;
      prev_q        <= w_prev;
      valid_pixel_q <= valid_pixel_d;
      rgb_q         <= rgb_d;
    end
  end

  assign valid_pixel = valid_pixel_q;
  assign r           = rgb_q[23:16];
  assign g           = rgb_q[15:8];
  assign b           = rgb_q[7:0];

endmodule

`default_nettype wire

// File: tb/tb_wave_display_core.sv
// ============================================================================
// Module   : tb_wave_display_core
// Purpose  : Self-checking bench for wave_display_core with a 1-cycle RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wave_display_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] x = '0;
  logic [9:0]  y = '0;
  logic        valid = 1'b0;
  logic [7:0]  read_value;
  logic [1:0]  weight = '0;
  logic        ff_switch0 = 1'b0;
  logic        r_switch1 = 1'b0;
  logic [1:0]  song_num = '0;
  logic        play = 1'b0;
  logic        read_index = 1'b0;
  logic [8:0]  read_address;
  logic        valid_pixel;
  logic [7:0]  r, g, b;

  int n_checks = 0;
  int n_fail   = 0;
  int ram_mode = 0;

  wave_display_core dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .valid(valid),
    .read_value(read_value), .weight(weight), .ff_switch0(ff_switch0),
    .r_switch1(r_switch1), .song_num(song_num), .play(play),
    .read_index(read_index), .read_address(read_address),
    .valid_pixel(valid_pixel), .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  // Sample RAM: mode 0 returns 136 everywhere (cur=100), mode 1 a ramp 2*addr
  initial read_value = 8'd0;
  always @(posedge clk)
    read_value <= (ram_mode == 0) ? 8'd136 : {read_address[6:0], 1'b0};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic apply(input logic [10:0] xi, input logic [9:0] yi, input logic vi, input logic [1:0] wi);
    @(negedge clk);
    x = xi; y = yi; valid = vi; weight = wi;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic expect_px(input string name, input logic vp, input logic [23:0] rgb);
    check({name, "_vp"}, {31'd0, valid_pixel}, {31'd0, vp});
    check({name, "_rgb"}, {8'd0, r, g, b}, {8'd0, rgb});
  endtask

  typedef struct {
    logic [10:0] x;
    logic [9:0]  y;
    logic        v;
    logic [1:0]  w;
    logic        vp;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs[18];

`ifdef WAVE_DISPLAY_ICONS_EN
  logic [63:0] glyph0 = 64'h3C66_6E76_6666_3C00;
`endif

  initial begin
    vecs[0]  = '{11'd0,   10'd1023, 1'b1, 2'd0, 1'b0, 24'h000000};
    vecs[1]  = '{11'd256, 10'd1023, 1'b1, 2'd0, 1'b0, 24'h000000};
    vecs[2]  = '{11'd512, 10'd1023, 1'b1, 2'd0, 1'b0, 24'h000000};
    vecs[3]  = '{11'd0,   10'd0,    1'b1, 2'd0, 1'b0, 24'h000000};
    vecs[4]  = '{11'd512, 10'd511,  1'b1, 2'd0, 1'b1, 24'h000000};
    vecs[5]  = '{11'd280, 10'd511,  1'b1, 2'd0, 1'b1, 24'h000000};
    vecs[6]  = '{11'd300, 10'd200,  1'b1, 2'd1, 1'b1, 24'hFFFFFF};
    vecs[7]  = '{11'd300, 10'd210,  1'b1, 2'd1, 1'b1, 24'h000000};
    vecs[8]  = '{11'd300, 10'd196,  1'b1, 2'd2, 1'b1, 24'hFFFFFF};
    vecs[9]  = '{11'd300, 10'd196,  1'b1, 2'd1, 1'b1, 24'h000000};
    vecs[10] = '{11'd300, 10'd204,  1'b1, 2'd2, 1'b1, 24'hFFFFFF};
    vecs[11] = '{11'd300, 10'd202,  1'b1, 2'd0, 1'b1, 24'h000000};
    vecs[12] = '{11'd300, 10'd201,  1'b1, 2'd0, 1'b1, 24'hFFFFFF};
    vecs[13] = '{11'd300, 10'd200,  1'b0, 2'd1, 1'b0, 24'h000000};
    vecs[14] = '{11'd767, 10'd200,  1'b1, 2'd0, 1'b1, 24'hFFFFFF};
    vecs[15] = '{11'd768, 10'd200,  1'b1, 2'd3, 1'b0, 24'h000000};
    vecs[16] = '{11'd255, 10'd200,  1'b1, 2'd3, 1'b0, 24'h000000};
    vecs[17] = '{11'd300, 10'd512,  1'b1, 2'd3, 1'b0, 24'h000000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    expect_px("reset_state", 1'b0, 24'h000000);
    @(negedge clk);
    reset = 1'b1;

    // Combinational address mapping
    @(negedge clk);
    read_index = 1'b1; x = 11'd767;
    #1 check("addr_767_idx1", {23'd0, read_address}, 32'h1FF);
    read_index = 1'b0; x = 11'd508;
    #1 check("addr_508_idx0", {23'd0, read_address}, 32'h07E);

    // Table-driven raster vectors against constant RAM (cur = prev = 100)
    for (int i = 0; i < 18; i++) begin
      apply(vecs[i].x, vecs[i].y, vecs[i].v, vecs[i].w);
      expect_px($sformatf("vec%0d", i), vecs[i].vp, vecs[i].rgb);
    end

    // Reset during an active trace, then resume
    apply(11'd300, 10'd200, 1'b1, 2'd1);
    expect_px("pre_reset", 1'b1, 24'hFFFFFF);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    expect_px("in_reset_1", 1'b0, 24'h000000);
    @(posedge clk); #1;
    expect_px("in_reset_2", 1'b0, 24'h000000);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    expect_px("post_reset_1", 1'b0, 24'h000000);
    @(posedge clk); #1;
    expect_px("post_reset_2", 1'b1, 24'hFFFFFF);

    // Ramp RAM: x=300 -> cur 54, x=320 -> cur 64; trace spans [54,64]
    ram_mode = 1;
    apply(11'd300, 10'd0, 1'b1, 2'd0);
    expect_px("ramp_hold", 1'b1, 24'h000000);
    apply(11'd320, 10'd120, 1'b1, 2'd0);
    expect_px("ramp_mid", 1'b1, 24'hFFFFFF);
    apply(11'd320, 10'd108, 1'b1, 2'd0);
    expect_px("ramp_lo_edge", 1'b1, 24'hFFFFFF);
    apply(11'd320, 10'd106, 1'b1, 2'd0);
    expect_px("ramp_below", 1'b1, 24'h000000);
    apply(11'd320, 10'd130, 1'b1, 2'd0);
    expect_px("ramp_above", 1'b1, 24'h000000);
    ram_mode = 0;

    // Icon region
    play = 1'b1; ff_switch0 = 1'b0;
`ifdef WAVE_DISPLAY_ICONS_EN
    apply(11'd828, 10'd483, 1'b1, 2'd0);
    expect_px("play_icon", 1'b0, 24'h00FF00);
    apply(11'd838, 10'd483, 1'b1, 2'd0);
    expect_px("ff_icon", 1'b0, 24'h404040);
    song_num = 2'd0;
    for (int ry = 0; ry < 8; ry++) begin
      for (int cx = 0; cx < 8; cx++) begin
        @(negedge clk);
        x = 11'(815 + cx); y = 10'(463 + ry);
        repeat (2) @(posedge clk);
        #1;
        check($sformatf("glyph_%0d_%0d", ry, cx), {8'd0, r, g, b},
              glyph0[63 - (ry * 8 + cx)] ? 32'h00FFFF00 : 32'h0);
      end
    end
`else
    apply(11'd828, 10'd483, 1'b1, 2'd0);
    expect_px("play_icon_off", 1'b0, 24'h000000);
    apply(11'd818, 10'd464, 1'b1, 2'd0);
    expect_px("glyph_off", 1'b0, 24'h000000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
